// File: rtl/aes_round_ctrl_if.sv
// Bundle between the AES round controller and its wrapper: start/ready input handshake,
// round-unit results, key request/response and valid/ready output handshake.
interface aes_round_ctrl_if;
  logic         start;
  logic [127:0] data_in;
  logic         ready;
  logic [127:0] state_q;
  logic [127:0] sub_out;
  logic [127:0] shift_out;
  logic [127:0] mix_out;
  logic         key_req;
  logic [3:0]   key_round;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic         sub_enable;
  logic         shift_enable;
  logic         mixcol_enable;
  logic [3:0]   round;
  logic         busy;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;

  // Handshakes: a block is taken on a rising edge with start && ready; a round key
  // is taken on a rising edge with key_req && round_key_valid; a result is taken
  // on a rising edge with out_valid && out_ready. Each valid holds until taken.
  modport slave (
    input  start, data_in, sub_out, shift_out, mix_out,
           round_key, round_key_valid, out_ready,
    output ready, state_q, key_req, key_round, sub_enable, shift_enable,
           mixcol_enable, round, busy, data_out, out_valid
  );

  modport master (
    output start, data_in, sub_out, shift_out, mix_out,
           round_key, round_key_valid, out_ready,
    input  ready, state_q, key_req, key_round, sub_enable, shift_enable,
           mixcol_enable, round, busy, data_out, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the state register and steps it through the shared
// combinational round units, fetching one round key per round. NR must lie in 2..15.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic              clk,
  input  logic              rst,
  aes_round_ctrl_if.slave   bus,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY   = 3'd1,
    SUB   = 3'd2,
    SHIFT = 3'd3,
    MIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       state, state_n;
  logic [127:0] st_r, st_n;
  logic [3:0]   round_r, round_n;

  logic         ready_c, busy_c, key_req_c, out_valid_c;
  logic         sub_en_c, shift_en_c, mix_en_c;
  logic [3:0]   key_round_c;
  logic [127:0] data_out_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      st_r    <= '0;
      round_r <= '0;
    end else begin
      state   <= state_n;
      st_r    <= st_n;
      round_r <= round_n;
    end
  end

  always_comb begin
    state_n     = state;
    st_n        = st_r;
    round_n     = round_r;
    ready_c     = 1'b0;
    busy_c      = 1'b1;
    key_req_c   = 1'b0;
    key_round_c = '0;
    sub_en_c    = 1'b0;
    shift_en_c  = 1'b0;
    mix_en_c    = 1'b0;
    out_valid_c = 1'b0;
    data_out_c  = '0;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        busy_c  = 1'b0;
        if (bus.start) begin
          st_n    = bus.data_in;
          round_n = '0;
          state_n = KEY;
        end
      end
      KEY: begin
        key_req_c   = 1'b1;
        key_round_c = round_r;
        if (bus.round_key_valid) begin
          st_n = st_r ^ bus.round_key;
          if (round_r == LAST_ROUND) begin
            state_n = DONE;
          end else begin
            round_n = round_r + 4'd1;
            state_n = SUB;
          end
        end
      end
      SUB: begin
        sub_en_c = 1'b1;
        st_n     = bus.sub_out;
        state_n  = SHIFT;
      end
      SHIFT: begin
        shift_en_c = 1'b1;
        st_n       = bus.shift_out;
        // The final round skips mix-columns and goes straight to its key.
        state_n    = (round_r == LAST_ROUND) ? KEY : MIX;
      end
      MIX: begin
        mix_en_c = 1'b1;
        st_n     = bus.mix_out;
        state_n  = KEY;
      end
      DONE: begin
        out_valid_c = 1'b1;
        data_out_c  = st_r;
        if (bus.out_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ready         = ready_c;
  assign bus.busy          = busy_c;
  assign bus.state_q       = st_r;
  assign bus.round         = round_r;
  assign bus.key_req       = key_req_c;
  assign bus.key_round     = key_round_c;
  assign bus.sub_enable    = sub_en_c;
  assign bus.shift_enable  = shift_en_c;
  assign bus.mixcol_enable = mix_en_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.data_out      = data_out_c;
  assign fsm_state         = state;

endmodule
